// File: rtl/zpu_wb_gpio.sv
// Wishbone pipelined-mode GPIO slave: data/direction registers, synchronised pads,
// per-pin edge interrupts with polarity select, and programmable ack wait states.
module zpu_wb_gpio #(
  parameter int GPIO_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [31:0]           wb_adr,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_stall,
  input  logic [GPIO_WIDTH-1:0] gpioin,
  output logic [GPIO_WIDTH-1:0] gpioout,
  output logic [GPIO_WIDTH-1:0] gpiodir,
  output logic                  irq
);

  typedef logic [GPIO_WIDTH-1:0] gpio_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [2:0] A_DIN  = 3'd0;
  localparam logic [2:0] A_OUT  = 3'd1;
  localparam logic [2:0] A_DIR  = 3'd2;
  localparam logic [2:0] A_EN   = 3'd3;
  localparam logic [2:0] A_POL  = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;

  function automatic gpio_t merge_lanes(input gpio_t old, input logic [31:0] data,
                                        input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~mask[GPIO_WIDTH-1:0]) | (data[GPIO_WIDTH-1:0] & mask[GPIO_WIDTH-1:0]);
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  adr_q;
  logic        we_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        ack_q, stall_q, irq_q;
  logic [31:0] dat_o_q;

  gpio_t out_q, out_d, dir_q, dir_d, en_q, en_d, pol_q, pol_d, stat_q, stat_d;
  gpio_t sync_q [SYNC_STAGES];
  gpio_t hist_q;
  gpio_t din, edge_set, clr;

  logic        commit, wr;
  logic [2:0]  cur_adr;
  logic        cur_we;
  logic [31:0] cur_dat, rdata, rdata_d;
  logic [3:0]  cur_sel;

  // Only the word offset is decoded; the remaining address bits are don't-care.
  logic unused_adr;
  assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

  // With zero wait states the commit happens on the accepting edge, so the live bus
  // fields must be used instead of the not-yet-latched copies.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_adr = wb_adr[4:2];
      cur_we  = wb_we;
      cur_dat = wb_dat_i;
      cur_sel = wb_sel;
    end else begin
      cur_adr = adr_q;
      cur_we  = we_q;
      cur_dat = dat_q;
      cur_sel = sel_q;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc && wb_stb) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_ACK;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign din      = sync_q[SYNC_STAGES-1];
  assign edge_set = (din & ~hist_q & pol_q) | (~din & hist_q & ~pol_q);
  assign wr       = commit && cur_we;

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    en_d  = en_q;
    pol_d = pol_q;
    clr   = '0;
    if (wr) begin
      case (cur_adr)
        A_OUT:   out_d = merge_lanes(out_q, cur_dat, cur_sel);
        A_DIR:   dir_d = merge_lanes(dir_q, cur_dat, cur_sel);
        A_EN:    en_d  = merge_lanes(en_q, cur_dat, cur_sel);
        A_POL:   pol_d = merge_lanes(pol_q, cur_dat, cur_sel);
        A_STAT:  clr   = merge_lanes('0, cur_dat, cur_sel);
        default: ;
      endcase
    end
    // A fresh edge in the same cycle as a write-1-to-clear keeps the bit set.
    stat_d = (stat_q & ~clr) | edge_set;
  end

  always_comb begin
    case (cur_adr)
      A_DIN:   rdata = 32'(din);
      A_OUT:   rdata = 32'(out_q);
      A_DIR:   rdata = 32'(dir_q);
      A_EN:    rdata = 32'(en_q);
      A_POL:   rdata = 32'(pol_q);
      A_STAT:  rdata = 32'(stat_q);
      default: rdata = 32'd0;
    endcase
    rdata_d = cur_we ? 32'd0 : rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      adr_q   <= 3'd0;
      we_q    <= 1'b0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
      dat_o_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == S_ACK);
      stall_q <= (state_d != S_IDLE);
      if (state_q == S_IDLE && wb_cyc && wb_stb) begin
        adr_q <= wb_adr[4:2];
        we_q  <= wb_we;
        dat_q <= wb_dat_i;
        sel_q <= wb_sel;
      end
      if (commit) dat_o_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      pol_q  <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      pol_q  <= pol_d;
      stat_q <= stat_d;
      irq_q  <= |(stat_q & en_q);
    end
  end

  // NOTE: the synchroniser and edge history are reset too, so no spurious edge is
  // seen on the first cycles after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= gpioin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= din;
    end
  end

  assign wb_dat_o = dat_o_q;
  assign wb_ack   = ack_q;
  assign wb_stall = stall_q;
  assign gpioout  = out_q;
  assign gpiodir  = dir_q;
  assign irq      = irq_q;

endmodule

// File: doc/zpu_wb_gpio.md
# zpu_wb_gpio

Parametrised Wishbone pipelined-mode slave implementing a GPIO bank with direction control and edge-triggered interrupts for the ZPU control top level. It replaces the fixed one-cycle `ackreg` responder and the loose gpioin/gpioout/gpiodir wiring with a register-mapped peripheral. It adds configurable wait states, input synchronisation and a level interrupt line suitable for the core's `interrupt` vector.

## Interface
- `GPIO_WIDTH`, 32: number of GPIO pins, 1..32; register bits above it read 0 and ignore writes.
- `WAIT_STATES`, 0: extra cycles between acceptance and ack, 0..7.
- `SYNC_STAGES`, 2: flip-flop stages on `gpioin`, 2..3.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wb_cyc`  in  1  bus cycle.
- `wb_stb`  in  1  strobe.
- `wb_we`  in  1  1 = write.
- `wb_adr`  in  32  byte address; only `[4:2]` decoded.
- `wb_dat_i`  in  32  write data.
- `wb_sel`  in  4  byte lanes for writes.
- `wb_dat_o`  out  32  read data, registered.
- `wb_ack`  out  1  one-cycle acknowledge.
- `wb_stall`  out  1  slave busy, registered.
- `gpioin`  in  GPIO_WIDTH  pad inputs, asynchronous.
- `gpioout`  out  GPIO_WIDTH  output data register.
- `gpiodir`  out  GPIO_WIDTH  1 = pin driven as output.
- `irq`  out  1  level interrupt, registered.

## Operation
- Register map by `wb_adr[4:2]`:
  - 0 DATA_IN (RO, synchronised pads).
  - 1 DATA_OUT (RW).
  - 2 DIR (RW).
  - 3 IRQ_EN (RW).
  - 4 IRQ_POL (RW; 1 = rising edge, 0 = falling edge).
  - 5 IRQ_STAT (read; write-1-to-clear).
  - 6 and 7 read 0; writes to them are ignored.
- Writes honour `wb_sel` per byte lane.
- Writes to DATA_IN have no effect but are still acked.
- FSM states:
  - IDLE: `wb_stall` = 0. When `wb_cyc & wb_stb` is sampled, latch adr/we/dat/sel. Go to WAIT if `WAIT_STATES` > 0, else go to ACK. Load a down-counter with `WAIT_STATES`-1.
  - WAIT: decrement the counter; at 0 go to ACK.
  - ACK: `wb_ack` = 1 for one cycle, then go to IDLE.
- `wb_stall` = 1 in WAIT and ACK. One transaction is outstanding at most.
- Abort: if `wb_cyc` drops in WAIT, return to IDLE with no ack and no register write.
- The write commits on the edge entering ACK. `wb_dat_o` is loaded on that same edge; it is 0 for writes.
- Edge detect: compare the last sync stage with its previous value. A selected-polarity edge sets the IRQ_STAT bit, regardless of IRQ_EN and regardless of DIR.
- Clear and edge in the same cycle: the set wins.
- `irq` is registered `|(IRQ_STAT & IRQ_EN)`.

## Timing
- Reset values: all registers 0; `wb_ack`, `wb_stall`, `irq` and `wb_dat_o` 0; sync chain and edge history 0; FSM in IDLE.
- Acceptance at edge T0. `wb_ack` is high during cycle T0+1+WAIT_STATES. `wb_stall` is high from T0+1 through the ack cycle.
- Throughput: one transaction per 2+WAIT_STATES cycles.
- With `WAIT_STATES`=0 the latency matches the legacy responder: ack is the cycle after stb.
- The `gpioout` and `gpiodir` update is visible in the ack cycle.
- Pad to DATA_IN: `SYNC_STAGES` edges.
- Pad edge to IRQ_STAT set: `SYNC_STAGES`+1 edges. `irq` follows one edge later.
- A W1C in the ack cycle drops `irq` one edge after the commit, unless a new edge re-sets the bit.
- Reset asserted mid-transaction: immediate return to IDLE with no ack. `wb_stall` and `wb_ack` go low asynchronously.

## Test plan
- Reset, then read all 8 offsets (W=0) → every read returns 0, each ack arrives 1 cycle after stb, and the stall pulse is 1 cycle.
- Write DATA_OUT=0xA5A5A5A5 with `wb_sel`=4'b0010, `GPIO_WIDTH`=16 → `gpioout`=0x0000A500 and readback 0x0000A500; bits above 15 read 0.
- `WAIT_STATES`=3: write DIR=0xFF, then issue back-to-back stb → ack at T0+4, the second request is held by stall and accepted at T0+5.
- IRQ_POL=1, IRQ_EN=0x1, raise `gpioin[0]` at edge E → IRQ_STAT=0x1 at E+3 and `irq`=1 at E+4; write IRQ_STAT=0x1 → `irq` falls.
- Falling edge on pin 1 coincident with a W1C of bit 1 → bit stays 1. Edge on pin 2 with IRQ_EN bit 2=0 → status is set and `irq` stays 0.
- Drop `wb_cyc` in WAIT (W=3) on a write of DATA_OUT → no ack and `gpioout` unchanged. Assert `rst` mid-WAIT → stall is 0 immediately and all registers are 0.
